// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pooling stage.
package pool_pkg;

    localparam int unsigned POOL_DATA_W = 8;
    localparam int unsigned POOL_CH_W   = 4;
    localparam int unsigned SMAX_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_WR   = 3'd5,
        ST_FIN  = 3'd6
    } state_e;

    // Signed maximum; callers sign-extend narrower words to SMAX_W first.
    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_window_counter.sv
// Window row/column counters plus read and write address generation.
module pool_window_counter
    import pool_pkg::*;
#(
    parameter int unsigned H          = 28,
    parameter int unsigned W          = 28,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned OUT_ADDR_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  adv_i,
    input  logic                  wr_cap_i,
    input  logic                  rd_en_i,
    input  logic [1:0]            rd_sel_i,
    output logic [ADDR_W-1:0]     rd_addr_o,
    output logic [OUT_ADDR_W-1:0] wr_addr_o,
    output logic                  last_c_o
);

    localparam int unsigned HP   = H / 2;
    localparam int unsigned WP   = W / 2;
    localparam int unsigned PR_W = (HP > 1) ? $clog2(HP) : 1;
    localparam int unsigned PC_W = (WP > 1) ? $clog2(WP) : 1;

    logic [PR_W-1:0]       pr_q, pr_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [OUT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           off_c;

    assign last_c_o = (32'(pr_q) == HP - 1) && (32'(pc_q) == WP - 1);

    // Column advances every window and wraps into the next row.
    always_comb begin
        pr_d = pr_q;
        pc_d = pc_q;
        if (clear_i) begin
            pr_d = '0;
            pc_d = '0;
        end else if (adv_i) begin
            if (32'(pc_q) == WP - 1) begin
                pc_d = '0;
                pr_d = pr_q + PR_W'(1);
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // Read address is prepared one cycle early from the next counter values.
    always_comb begin
        off_c = 32'd0;
        unique case (rd_sel_i)
            2'd0:    off_c = 32'd0;
            2'd1:    off_c = 32'd1;
            2'd2:    off_c = W;
            default: off_c = W + 32'd1;
        endcase
        rd_addr_d = '0;
        if (rd_en_i) begin
            rd_addr_d = ADDR_W'(32'(pr_d) * (2 * W) + 32'(pc_d) * 32'd2 + off_c);
        end
        wr_addr_d = wr_addr_q;
        if (wr_cap_i) begin
            wr_addr_d = OUT_ADDR_W'(32'(pr_q) * WP + 32'(pc_q));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pr_q      <= '0;
            pc_q      <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            pr_q      <= pr_d;
            pc_q      <= pc_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign wr_addr_o = wr_addr_q;

endmodule

// File: rtl/maxpool_stage.sv
// 2x2 stride-2 signed max-pooling of one feature-map channel per start pulse.
// Defining MAXPOOL_RELU_EN clamps negative pooled results to zero.
module maxpool_stage
    import pool_pkg::*;
#(
    parameter int unsigned H          = 28,
    parameter int unsigned W          = 28,
    parameter int unsigned DATA_W     = POOL_DATA_W,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned OUT_ADDR_W = 8,
    parameter int unsigned CH_W       = POOL_CH_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CH_W-1:0]       ch_in_i,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [DATA_W-1:0]     rd_data_i,
    output logic                  wr_en_o,
    output logic [OUT_ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic [CH_W-1:0]       wr_ch_o,
    output logic                  busy_o,
    output logic                  done_o
);

    state_e                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic signed [DATA_W-1:0]  max_q, max_d;
    logic signed [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      wr_en_q, wr_en_d;

    logic signed [DATA_W-1:0]  rd_s_c;
    logic signed [DATA_W-1:0]  cmp_c;
    logic signed [DATA_W-1:0]  pooled_c;
    logic                      clear_c, adv_c, wr_cap_c, rd_en_c, last_c;
    logic [1:0]                rd_sel_c;

    assign rd_s_c = rd_data_i;
    assign cmp_c  = DATA_W'(smax(SMAX_W'(max_q), SMAX_W'(rd_s_c)));

`ifdef MAXPOOL_RELU_EN
    assign pooled_c = cmp_c[DATA_W-1] ? '0 : cmp_c;
`else
    assign pooled_c = cmp_c;
`endif

    pool_window_counter #(
        .H          (H),
        .W          (W),
        .ADDR_W     (ADDR_W),
        .OUT_ADDR_W (OUT_ADDR_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_c),
        .adv_i     (adv_c),
        .wr_cap_i  (wr_cap_c),
        .rd_en_i   (rd_en_c),
        .rd_sel_i  (rd_sel_c),
        .rd_addr_o (rd_addr_o),
        .wr_addr_o (wr_addr_o),
        .last_c_o  (last_c)
    );

    // Four reads per window; the max register trails the read data by one cycle.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        max_d     = max_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        clear_c   = 1'b0;
        adv_c     = 1'b0;
        wr_cap_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    ch_d    = ch_in_i;
                    busy_d  = 1'b1;
                    clear_c = 1'b1;
                    state_d = ST_RD0;
                end
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: begin
                max_d   = rd_s_c;
                state_d = ST_RD2;
            end
            ST_RD2: begin
                max_d   = cmp_c;
                state_d = ST_RD3;
            end
            ST_RD3: begin
                max_d   = cmp_c;
                state_d = ST_WR;
            end
            ST_WR: begin
                wr_en_d   = 1'b1;
                wr_data_d = pooled_c;
                wr_cap_c  = 1'b1;
                if (last_c) begin
                    state_d = ST_FIN;
                end else begin
                    adv_c   = 1'b1;
                    state_d = ST_RD0;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read strobe and sample offset follow the state being entered.
    always_comb begin
        rd_en_c  = 1'b0;
        rd_sel_c = 2'd0;
        unique case (state_d)
            ST_RD0: begin rd_en_c = 1'b1; rd_sel_c = 2'd0; end
            ST_RD1: begin rd_en_c = 1'b1; rd_sel_c = 2'd1; end
            ST_RD2: begin rd_en_c = 1'b1; rd_sel_c = 2'd2; end
            ST_RD3: begin rd_en_c = 1'b1; rd_sel_c = 2'd3; end
            default: begin rd_en_c = 1'b0; rd_sel_c = 2'd0; end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            max_q     <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            max_q     <= max_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_data_o = wr_data_q;
    assign wr_ch_o   = ch_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
